// File: rtl/p_game_mmio_pkg.sv
// -----------------------------------------------------------------------------
// p_game_mmio_pkg
// Shared constants for the game MMIO bridge: register word offsets inside the
// 16-word window, STATUS field positions, CTRL bit positions, and the sticky
// flag bundle used by the top module.
// Build option: P_GAME_MMIO_IRQ_EN (see p_game_mmio.sv).
// -----------------------------------------------------------------------------
package p_game_mmio_pkg;

  // The window is 16 words, so the low 4 address bits select the register.
  localparam int unsigned WIN_BITS = 4;

  localparam logic [WIN_BITS-1:0] OFF_STATUS = 4'd0;
  localparam logic [WIN_BITS-1:0] OFF_POP    = 4'd1;
  localparam logic [WIN_BITS-1:0] OFF_CTRL   = 4'd2;
  localparam logic [WIN_BITS-1:0] OFF_OUT0   = 4'd4;

  // STATUS bit positions
  localparam int unsigned STAT_NONEMPTY  = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERFLOW  = 2;
  localparam int unsigned STAT_UNDERFLOW = 3;
  localparam int unsigned STAT_OVERWRITE = 4;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_COUNT_W   = 7;
  localparam int unsigned STAT_VALID_LSB = 16;

  // CTRL bit positions
  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_CLEAR  = 31;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic overwrite;
  } sticky_t;

  // Word offset of output channel k.
  function automatic logic [WIN_BITS-1:0] out_offset(input int unsigned k);
    return OFF_OUT0 + WIN_BITS'(k);
  endfunction

endpackage

// File: rtl/p_sync_fifo.sv
// -----------------------------------------------------------------------------
// p_sync_fifo
// Single-clock FIFO with registered occupancy count. No bypass: a word pushed
// while empty is visible only after the push edge. Pushes while full and pops
// while empty are ignored.
// Ports:
//   i_clock, i_reset   clock, synchronous active-high reset
//   i_push, i_data     write request and data
//   i_pop              read request (head advances at the edge)
//   o_data             current head word
//   o_full, o_empty    occupancy flags
//   o_count            entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module p_sync_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the count and pointers define which entries
  // are meaningful, so clearing the array would only cost reset fan-out.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/p_game_mmio.sv
// -----------------------------------------------------------------------------
// p_game_mmio
// Memory-mapped bridge between the processor data bus and the Tetris game
// logic. Decodes a 16-word window at BASE_ADDR holding STATUS, POP, CTRL and
// NUM_OUT output channel registers; game events arrive through an input FIFO.
// Build option: define P_GAME_MMIO_IRQ_EN to build the level interrupt and the
// writable CTRL.irq_en bit; otherwise o_irq is tied low.
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_bus_addr/wdata/wren/rden processor bus (word address)
//   o_bus_hit                 address lies inside the window (combinational)
//   o_bus_rdata               registered read data, held between reads
//   i_game_in_data/valid      game event push, o_game_in_ready = FIFO not full
//   o_game_out_data/valid     per-channel word and pending flag
//   i_game_out_ack            game consumed channel k
//   o_irq                     level interrupt
// -----------------------------------------------------------------------------
module p_game_mmio
  import p_game_mmio_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 12'hF00,
  parameter int unsigned       NUM_OUT    = 2,
  parameter int unsigned       FIFO_DEPTH = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [ADDR_W-1:0]         i_bus_addr,
  input  logic [DATA_W-1:0]         i_bus_wdata,
  input  logic                      i_bus_wren,
  input  logic                      i_bus_rden,
  output logic                      o_bus_hit,
  output logic [DATA_W-1:0]         o_bus_rdata,
  input  logic [DATA_W-1:0]         i_game_in_data,
  input  logic                      i_game_in_valid,
  output logic                      o_game_in_ready,
  output logic [NUM_OUT*DATA_W-1:0] o_game_out_data,
  output logic [NUM_OUT-1:0]        o_game_out_valid,
  input  logic [NUM_OUT-1:0]        i_game_out_ack,
  output logic                      o_irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  logic [WIN_BITS-1:0] w_offset;
  logic                w_rd;
  logic                w_wr;
  logic                w_sel_status;
  logic                w_sel_pop;
  logic                w_sel_ctrl;
  logic [NUM_OUT-1:0]  w_out_sel;

  assign o_bus_hit    = (i_bus_addr[ADDR_W-1:WIN_BITS] == BASE_ADDR[ADDR_W-1:WIN_BITS]);
  assign w_offset     = i_bus_addr[WIN_BITS-1:0];
  assign w_rd         = i_bus_rden & o_bus_hit;
  assign w_wr         = i_bus_wren & o_bus_hit;
  assign w_sel_status = (w_offset == OFF_STATUS);
  assign w_sel_pop    = (w_offset == OFF_POP);
  assign w_sel_ctrl   = (w_offset == OFF_CTRL);

  // Offsets 4+k with k >= NUM_OUT match nothing and fall through to zero.
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out_sel
    assign w_out_sel[g] = (w_offset == out_offset(g));
  end

  // ---------------------------------------------------------------- input FIFO
  logic [DATA_W-1:0] w_fifo_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_pop_req;
  logic              w_underflow_evt;

  assign w_pop_req       = w_rd & w_sel_pop;
  assign w_underflow_evt = w_pop_req & w_fifo_empty;

  p_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (i_game_in_valid),
    .i_data  (i_game_in_data),
    .i_pop   (w_pop_req),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Held low during reset so the game never pushes into a FIFO being flushed.
  assign o_game_in_ready = ~w_fifo_full & ~i_reset;

  // ---------------------------------------------------------------- output channels
  logic [NUM_OUT*DATA_W-1:0] r_out_data;
  logic [NUM_OUT-1:0]        r_out_valid;

  // A bus write to a channel takes priority over a same-cycle ack.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_out_data  <= '0;
      r_out_valid <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_wr & w_out_sel[k]) begin
          r_out_data[k*DATA_W +: DATA_W] <= i_bus_wdata;
          r_out_valid[k]                 <= 1'b1;
        end else if (i_game_out_ack[k]) begin
          r_out_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign o_game_out_data  = r_out_data;
  assign o_game_out_valid = r_out_valid;

  // ---------------------------------------------------------------- sticky flags
  sticky_t r_sticky;
  logic    w_clear;

  assign w_clear = w_wr & w_sel_ctrl & i_bus_wdata[CTRL_CLEAR];

  // NOTE: non-blocking assignments; a later assignment in this block overrides
  // the clear, so an event landing in the same cycle as a clear stays recorded.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sticky <= '0;
    end else begin
      if (w_clear)                            r_sticky           <= '0;
      if (i_game_in_valid & w_fifo_full)      r_sticky.overflow  <= 1'b1;
      if (w_underflow_evt)                    r_sticky.underflow <= 1'b1;
      if (w_wr & |(w_out_sel & r_out_valid))  r_sticky.overwrite <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- interrupt
  logic w_irq_en;

`ifdef P_GAME_MMIO_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr & w_sel_ctrl) r_irq_en <= i_bus_wdata[CTRL_IRQ_EN];
      r_irq <= r_irq_en & (~w_fifo_empty | r_sticky.overflow);
    end
  end

  assign w_irq_en = r_irq_en;
  assign o_irq    = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign o_irq    = 1'b0;
`endif

  // ---------------------------------------------------------------- read path
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rdata_next;
  logic [DATA_W-1:0] r_rdata;

  always_comb begin
    w_status                                = '0;
    w_status[STAT_NONEMPTY]                 = ~w_fifo_empty;
    w_status[STAT_FULL]                     = w_fifo_full;
    w_status[STAT_OVERFLOW]                 = r_sticky.overflow;
    w_status[STAT_UNDERFLOW]                = r_sticky.underflow;
    w_status[STAT_OVERWRITE]                = r_sticky.overwrite;
    w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_fifo_count);
    w_status[STAT_VALID_LSB +: NUM_OUT]     = r_out_valid;
  end

  // All sources are pre-edge state, so a combined write+read returns old data.
  always_comb begin
    w_rdata_next = '0;
    if (w_sel_status) begin
      w_rdata_next = w_status;
    end else if (w_sel_pop) begin
      w_rdata_next = w_fifo_empty ? '0 : w_fifo_head;
    end else if (w_sel_ctrl) begin
      w_rdata_next[CTRL_IRQ_EN] = w_irq_en;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_out_sel[k]) w_rdata_next = r_out_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rdata_next;
    end
  end

  assign o_bus_rdata = r_rdata;

endmodule

// File: doc/p_game_mmio.md
# p_game_mmio

Parametrised memory-mapped bridge between the processor's data-memory bus and the Tetris game logic. It replaces fixed register-file taps such as `data_from_game`, `data_to_game`, `shape_num` and `point_xy` with an address window. Inside that window:
- an input FIFO buffers game events;
- NUM_OUT output channels hand words to the game with a valid/ack handshake.

It sits beside `p_dmem` under the skeleton and decodes its own window from the same bus.

## Interface
Parameters:
- DATA_W, 32, bus and channel word width
- ADDR_W, 12, word-address width (matches dmem)
- BASE_ADDR, 12'hF00, window base; must be 16-word aligned
- NUM_OUT, 2, output channels, 1..8
- FIFO_DEPTH, 8, input FIFO entries, power of two, 2..64

Ports:
- clock  in  1  single clock for everything
- reset  in  1  synchronous, active-high
- bus_addr  in  ADDR_W  word address from processor
- bus_wdata  in  DATA_W  write data
- bus_wren  in  1  write strobe
- bus_rden  in  1  read strobe
- bus_hit  out  1  combinational: bus_addr is inside the 16-word window
- bus_rdata  out  DATA_W  registered read data
- game_in_data  in  DATA_W  event word from game
- game_in_valid  in  1  push request
- game_in_ready  out  1  FIFO not full
- game_out_data  out  NUM_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- game_out_valid  out  NUM_OUT  channel k word pending
- game_out_ack  in  NUM_OUT  game consumed channel k
- irq  out  1  level interrupt

## Operation
Word offsets are relative to BASE_ADDR:
- 0 STATUS (RO):
  - bit0 FIFO non-empty
  - bit1 FIFO full
  - bit2 overflow (sticky)
  - bit3 underflow (sticky)
  - bit4 overwrite (sticky)
  - bits[14:8] FIFO count
  - bits[23:16] game_out_valid mask
- 1 POP (RO, side effect):
  - If non-empty: returns the head and pops it.
  - If empty: returns 0, no pop, sets underflow.
- 2 CTRL (RW):
  - bit0 irq_en.
  - Writing bit31=1 clears all sticky bits; bit31 reads 0.
- 4+k OUT_k (RW), k < NUM_OUT:
  - A write loads channel k and sets game_out_valid[k].
  - A read returns the current channel data.
  - Writing while valid[k]=1 replaces the data, keeps valid high and sets overwrite.
- Unused offsets and OUT_k with k >= NUM_OUT: read 0, writes ignored.

Input FIFO:
- A push happens when game_in_valid & game_in_ready.
- game_in_valid while full: word dropped, overflow set, FIFO unchanged.

Output handshake:
- game_out_ack[k] while valid[k]: valid[k] clears next cycle, data retained.
- Ack while not valid: ignored.

Simultaneous events:
- Push and pop in the same cycle on a non-empty FIFO: count unchanged, order preserved.
- Pop while empty with a concurrent push: no bypass. Pop returns 0 and sets underflow; the pushed word is stored.
- OUT_k write and ack[k] in the same cycle: the write wins and valid stays 1.
- bus_wren and bus_rden together: write performed, read data returned from pre-write state.
- Strobes outside the window: no effect and no pop.

## Timing
- bus_rdata is registered: a read issued at edge N appears after edge N+1. It holds its value until the next in-window read.
- Pop takes effect at the same edge the read is sampled.
- STATUS/POP reflect state before that edge's updates.
- Write to OUT_k: game_out_valid[k] rises 1 cycle later.
- game_in_ready = !full, combinational from registered count. It is 0 while reset is high.
- Reset values, all outputs:
  - bus_rdata 0
  - game_out_data 0
  - game_out_valid 0
  - irq 0
  - game_in_ready 0 during reset, 1 in the first cycle after
- Reset also clears all sticky bits and irq_en.
- Reset mid-operation: the FIFO is flushed, pending output words are discarded, and in-flight reads return 0.
- Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits so full and empty are distinguished.

## Configuration
- P_GAME_MMIO_IRQ_EN defined:
  - irq = irq_en & (non-empty | overflow), registered, rising 1 cycle after the cause.
  - CTRL bit0 is writable.
- P_GAME_MMIO_IRQ_EN undefined:
  - irq port retained but tied 0.
  - CTRL bit0 reads 0 and ignores writes.
  - No irq logic synthesised.

## Structure
- Package p_game_mmio_pkg holds:
  - register offset localparams (OFF_STATUS, OFF_POP, OFF_CTRL, OFF_OUT0)
  - STATUS bit-index constants
  - the CTRL clear-bit index
- Sub-module p_sync_fifo:
  - parametrised by width and depth
  - push/pop, full/empty/count, no bypass
- Decode, channel registers and sticky flags live in the top module.

## Test plan
- Reset, then push 0xA1, 0xB2, 0xC3 from the game; read POP three times -> 0xA1, 0xB2, 0xC3 in order; STATUS count 0; a fourth POP -> 0 and underflow=1.
- Fill all 8 entries -> game_in_ready=0, full=1; push 0xDEAD while full -> overflow=1 and count stays 8; CTRL write 0x8000_0000 -> sticky bits clear.
- Write OUT_1=0x0005_0003 -> valid[1] high next cycle with data correct; hold ack low 5 cycles and valid stays; pulse ack[1] -> valid[1] low the following cycle.
- Write OUT_0 and assert ack[0] in the same cycle -> valid[0] remains 1 with the new data; a second write while pending sets overwrite.
- With P_GAME_MMIO_IRQ_EN: irq_en=1, push one word -> irq high 1 cycle later; POP it -> irq low. Without the macro: irq stays 0 throughout.
- Assert reset with 3 words queued and valid[0]=1 -> next cycle count=0, all valids 0, bus_rdata 0, game_in_ready 1 after reset releases.
